weight_loader: RTL and testbench

Host-facing loader that fills the synapse weight bank from a byte stream, as opposed to generating weights internally. Weights arrive over a valid/ready stream, are stored in order at auto-incrementing addresses, and drive the flattened weight bus consumed by the neuron array. A readback mode streams the bank back out, again over valid/ready, so the host can verify what was loaded.

---
 rtl/weight_loader.sv | 126 ++++++++++++
 tb/tb_weight_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - host-streamed synapse weight bank with ordered load and valid/ready readback
module weight_loader #(
    parameter  int NUM_SYNAPSES = 100,
    parameter  int WIDTH_P      = 8,
    localparam int PTR_W        = $clog2(NUM_SYNAPSES)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            load_start_i,
    input  logic                            rd_start_i,
    input  logic [WIDTH_P-1:0]              data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [WIDTH_P-1:0]              rd_data_o,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_o,
    output logic [WIDTH_P+PTR_W:0]          sum_o,
    output logic                            loaded_o,
    output logic                            busy_o
);

    localparam int SUM_W = WIDTH_P + PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SYNAPSES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               loaded_q, loaded_d;
    logic               wr_en;
    logic [WIDTH_P-1:0] bank_q [NUM_SYNAPSES];

    // load_start_i takes priority over every other event in every state
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sum_d    = sum_q;
        loaded_d = loaded_q;
        wr_en    = 1'b0;
        if (load_start_i) begin
            state_d  = ST_LOAD;
            ptr_d    = '0;
            sum_d    = '0;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_start_i) begin
                        state_d = ST_DUMP;
                        ptr_d   = '0;
                    end
                end
                ST_LOAD: begin
                    if (valid_i) begin
                        wr_en = 1'b1;
                        sum_d = sum_q + SUM_W'(data_i);
                        if (ptr_q == LAST_PTR) begin
                            ptr_d    = '0;
                            loaded_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (rd_start_i) begin
                        ptr_d = '0;
                    end else if (rd_ready_i) begin
                        if (ptr_q == LAST_PTR) begin
                            ptr_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            sum_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sum_q    <= sum_d;
            loaded_q <= loaded_d;
        end
    end

    // the bank itself is cleared by reset so a mid-transfer reset leaves no stale weights
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SYNAPSES; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en) begin
            bank_q[ptr_q] <= data_i;
        end
    end

    for (genvar g = 0; g < NUM_SYNAPSES; g++) begin : g_flat
        assign weights_o[g*WIDTH_P +: WIDTH_P] = bank_q[g];
    end

    assign ready_o    = (state_q == ST_LOAD);
    assign rd_valid_o = (state_q == ST_DUMP);
    assign busy_o     = (state_q != ST_IDLE);
    assign rd_data_o  = (state_q == ST_DUMP) ? bank_q[ptr_q] : '0;
    assign sum_o      = sum_q;
    assign loaded_o   = loaded_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - self-checking bench for weight_loader against a transaction-level bank model
module tb_weight_loader;

    localparam int N  = 100;
    localparam int W  = 8;
    localparam int PW = $clog2(N);
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, rd_start, valid, rd_ready;
    logic [W-1:0]  data;
    logic          ready, rd_valid, loaded, busy;
    logic [W-1:0]  rd_data;
    logic [NW-1:0] weights;
    logic [W+PW:0] sum;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: mode 0 idle, 1 load, 2 dump
    int m_bank [N];
    int m_mode, m_idx, m_sum, m_accepts;
    bit m_loaded;

    logic [NW-1:0] snap;

    weight_loader #(.NUM_SYNAPSES(N), .WIDTH_P(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .load_start_i(load_start), .rd_start_i(rd_start),
        .data_i(data), .valid_i(valid), .ready_o(ready), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .weights_o(weights),
        .sum_o(sum), .loaded_o(loaded), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] model_weights();
        logic [NW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_bank[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_bank[i] = 0;
        m_mode = 0; m_idx = 0; m_sum = 0; m_loaded = 0; m_accepts = 0;
    endtask

    // apply the rules to the inputs presented this cycle, then let the clock edge happen
    task automatic cycle();
        if (load_start) begin
            m_mode = 1; m_idx = 0; m_sum = 0; m_loaded = 0; m_accepts = 0;
        end else if (m_mode == 1) begin
            if (valid) begin
                m_bank[m_idx] = int'(data);
                m_sum += int'(data);
                m_accepts++;
                m_idx++;
                if (m_idx == N) begin m_idx = 0; m_loaded = 1; m_mode = 0; end
            end
        end else if (m_mode == 2) begin
            if (rd_start) m_idx = 0;
            else if (rd_ready) begin
                m_idx++;
                if (m_idx == N) begin m_idx = 0; m_mode = 0; end
            end
        end else if (rd_start) begin
            m_mode = 2; m_idx = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ready"},    NW'(ready),    NW'(m_mode == 1));
        chk({tag, "_rd_valid"}, NW'(rd_valid), NW'(m_mode == 2));
        chk({tag, "_busy"},     NW'(busy),     NW'(m_mode != 0));
        chk({tag, "_loaded"},   NW'(loaded),   NW'(m_loaded));
        chk({tag, "_sum"},      NW'(sum),      NW'(m_sum));
        chk({tag, "_rd_data"},  NW'(rd_data),  (m_mode == 2) ? NW'(m_bank[m_idx]) : '0);
        chk({tag, "_weights"},  weights,       model_weights());
    endtask

    initial begin
        rst_n = 1'b0; load_start = 0; rd_start = 0; valid = 0; rd_ready = 0; data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_weights_zero", weights, '0);
        rst_n = 1'b1;

        // 1: sequential load 0..99 with valid held high
        load_start = 1; cycle(); load_start = 0;
        check_all("t1_start");
        for (int i = 0; i < N; i++) begin
            data = W'(i); valid = 1;
            chk("t1_ready_each_beat", NW'(ready), 1);
            cycle();
            check_all("t1_beat");
        end
        chk("t1_sum_4950", NW'(sum), 4950);
        chk("t1_loaded", NW'(loaded), 1);
        chk("t1_ready_low", NW'(ready), 0);
        data = 8'hAA; cycle(); check_all("t1_extra");
        valid = 0;

        // 3: readback with stalls on words 0 and 50
        rd_start = 1; cycle(); rd_start = 0; rd_ready = 1;
        check_all("t3_start");
        for (int w = 0; w < N; w++) begin
            if (w == 0 || w == 50) begin
                rd_ready = 0;
                repeat (3) begin
                    cycle();
                    chk("t3_stall_stable", NW'(rd_data), NW'(w));
                    check_all("t3_stall");
                end
                rd_ready = 1;
            end
            chk("t3_word", NW'(rd_data), NW'(w));
            chk("t3_word_valid", NW'(rd_valid), 1);
            cycle();
            check_all("t3_rd");
        end
        rd_ready = 0;
        chk("t3_idle_after", NW'(busy), 0);
        chk("t3_sum_kept", NW'(sum), 4950);
        chk("t3_loaded_kept", NW'(loaded), 1);

        // 5: simultaneous starts from IDLE, then rd_start during LOAD
        load_start = 1; rd_start = 1; cycle(); load_start = 0; rd_start = 0;
        chk("t5_ready", NW'(ready), 1);
        chk("t5_rd_valid", NW'(rd_valid), 0);
        check_all("t5_both");
        rd_start = 1; cycle(); rd_start = 0;
        chk("t5_ignored_ready", NW'(ready), 1);
        chk("t5_ignored_rd_valid", NW'(rd_valid), 0);
        check_all("t5_ignored");

        // 4: restart after 40 beats
        for (int i = 0; i < 40; i++) begin
            data = W'($urandom); valid = 1; cycle(); check_all("t4_pre");
        end
        valid = 0; load_start = 1; cycle(); load_start = 0;
        chk("t4_loaded_clr", NW'(loaded), 0);
        chk("t4_sum_clr", NW'(sum), 0);
        for (int k = 40; k < N; k++) chk("t4_old_entry", NW'(weights[k*W +: W]), NW'(k));
        check_all("t4_restart");
        for (int i = 0; i < N; i++) begin
            data = W'($urandom); valid = 1; cycle(); check_all("t4_beat");
        end
        valid = 0;
        chk("t4_loaded", NW'(loaded), 1);

        // 2: random valid, then valid held after completion
        load_start = 1; cycle(); load_start = 0;
        for (int c = 0; c < 2000 && !m_loaded; c++) begin
            valid = 1'($urandom); data = W'($urandom); cycle(); check_all("t2_beat");
        end
        chk("t2_complete", NW'(loaded), 1);
        chk("t2_accept_count", NW'(m_accepts), NW'(N));
        snap = weights;
        valid = 1; data = W'($urandom);
        repeat (2) cycle();
        check_all("t2_extra");
        chk("t2_bank_unchanged", weights, snap);
        valid = 0;

        // 6: asynchronous reset mid-DUMP
        rd_start = 1; cycle(); rd_start = 0; rd_ready = 1;
        repeat (5) begin cycle(); check_all("t6_rd"); end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_weights_zero", weights, '0);
        chk("t6_rd_data_zero", NW'(rd_data), 0);
        rd_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check_all("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
